// File: rtl/arb_req_queue_pkg.sv
// Shared constants and helpers for the arbitrated request queue.
//   NUM_PORTS  - number of requesting ports
//   PORT_W     - width of a port index
//   DEF_DATA_W - default payload width
//   DEF_DEPTH  - default entries per port queue
//   onehot_idx - binary index of the set bit of a one-hot vector
package arb_req_queue_pkg;

    localparam int NUM_PORTS  = 4;
    localparam int PORT_W     = 2;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 4;

    function automatic logic [PORT_W-1:0] onehot_idx(input logic [NUM_PORTS-1:0] v);
        logic [PORT_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (v[i]) idx = PORT_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb_port_fifo.sv
// Single-port request FIFO with registered occupancy count.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   wr_valid    - write strobe; word taken only when wr_ready=1
//   wr_data     - write payload
//   wr_ready    - space available, decoded from registered count
//   rd_en       - pop the head (ignored when empty)
//   not_empty   - at least one entry stored, decoded from registered count
//   rd_data     - current head entry
module arb_port_fifo
    import arb_req_queue_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_en,
    output logic              not_empty,
    output logic [DATA_W-1:0] rd_data
);

    localparam int             PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              push;
    logic              pop;

    // No bypass: a pop in this cycle does not free space for a push in this cycle.
    assign wr_ready  = (count != FULL_CNT);
    assign not_empty = (count != '0);
    assign push      = wr_valid & wr_ready;
    assign pop       = rd_en & not_empty;
    assign rd_data   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/arb_req_queue.sv
// Four per-port request queues feeding an external round-robin arbiter.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   in_valid   - per-port write strobe
//   in_data    - per-port payload, port i at [i*DATA_W +: DATA_W]
//   in_ready   - per-port space available
//   REQ        - per-port non-empty request to the arbiter
//   GNT        - arbiter grant, legal only when one-hot on a requesting port
//   out_valid  - registered pulse, one cycle after a legal grant
//   out_data   - dequeued payload (holds when out_valid=0)
//   out_port   - source port of out_data (holds when out_valid=0)
//   err_gnt    - registered pulse for an illegal grant
module arb_req_queue
    import arb_req_queue_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        in_valid,
    input  logic [NUM_PORTS*DATA_W-1:0] in_data,
    output logic [NUM_PORTS-1:0]        in_ready,
    output logic [NUM_PORTS-1:0]        REQ,
    input  logic [NUM_PORTS-1:0]        GNT,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic [PORT_W-1:0]           out_port,
    output logic                        err_gnt
);

    logic [DATA_W-1:0]    head [NUM_PORTS];
    logic [NUM_PORTS-1:0] not_empty;
    logic [NUM_PORTS-1:0] pop_p0;
    logic                 gnt_onehot_p0;
    logic                 gnt_legal_p0;
    logic                 gnt_illegal_p0;
    logic [PORT_W-1:0]    gnt_idx_p0;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        arb_port_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .wr_valid  (in_valid[i]),
            .wr_data   (in_data[i*DATA_W +: DATA_W]),
            .wr_ready  (in_ready[i]),
            .rd_en     (pop_p0[i]),
            .not_empty (not_empty[i]),
            .rd_data   (head[i])
        );
    end

    assign REQ = not_empty;

    // Stage p0: grant decode and legality check against registered REQ
    always_comb begin
        gnt_onehot_p0  = (GNT != '0) && ((GNT & (GNT - NUM_PORTS'(1))) == '0);
        gnt_legal_p0   = gnt_onehot_p0 && ((GNT & REQ) != '0);
        gnt_illegal_p0 = (GNT != '0) && !gnt_legal_p0;
        gnt_idx_p0     = onehot_idx(GNT);
        pop_p0         = gnt_legal_p0 ? GNT : '0;
    end

    // Stage p1: registered outputs; data and port hold between pops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_port  <= '0;
            err_gnt   <= 1'b0;
        end else begin
            out_valid <= gnt_legal_p0;
            err_gnt   <= gnt_illegal_p0;
            if (gnt_legal_p0) begin
                out_data <= head[gnt_idx_p0];
                out_port <= gnt_idx_p0;
            end
        end
    end

endmodule

// File: tb/tb_arb_req_queue.sv
module tb_arb_req_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic [3:0]  REQ;
    logic [3:0]  GNT;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_port;
    logic        err_gnt;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        logic [1:0] port;
    } exp_t;

    exp_t exp_q[$];

    arb_req_queue #(.DATA_W(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .REQ       (REQ),
        .GNT       (GNT),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_port  (out_port),
        .err_gnt   (err_gnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [7:0] d, input logic [1:0] p);
        exp_t e;
        e.is_err = 1'b0;
        e.data   = d;
        e.port   = p;
        exp_q.push_back(e);
    endtask

    task automatic expect_err();
        exp_t e;
        e.is_err = 1'b1;
        e.data   = '0;
        e.port   = '0;
        exp_q.push_back(e);
    endtask

    task automatic push1(input int p, input logic [7:0] d);
        in_valid    = 4'b0001 << p;
        in_data     = '0;
        in_data[p*8 +: 8] = d;
        tick();
        in_valid = '0;
    endtask

    task automatic push_all(input logic [31:0] d);
        in_valid = 4'b1111;
        in_data  = d;
        tick();
        in_valid = '0;
    endtask

    task automatic grant(input logic [3:0] g);
        GNT = g;
        tick();
        GNT = '0;
    endtask

    // Scoreboard monitor: every output or error pulse must match the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid || err_gnt) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_output: valid=%0b err=%0b data=%0h port=%0d, expected nothing",
                             out_valid, err_gnt, out_data, out_port);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.is_err) begin
                        if (!err_gnt || out_valid) begin
                            bad++;
                            $display("FAIL err_pulse: valid=%0b err=%0b, expected valid=0 err=1",
                                     out_valid, err_gnt);
                        end
                    end else if (!out_valid || err_gnt || out_data !== e.data || out_port !== e.port) begin
                        bad++;
                        $display("FAIL out_word: valid=%0b err=%0b data=%0h port=%0d, expected valid=1 err=0 data=%0h port=%0d",
                                 out_valid, err_gnt, out_data, out_port, e.data, e.port);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = '0;
        in_data  = '0;
        GNT      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {28'd0, in_ready}, 32'hF);
        check("rst_req", {28'd0, REQ}, 32'h0);
        check("rst_out_valid", {31'd0, out_valid}, 32'h0);
        check("rst_out_data", {24'd0, out_data}, 32'h0);
        check("rst_out_port", {30'd0, out_port}, 32'h0);
        check("rst_err", {31'd0, err_gnt}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Single word through port 0
        push1(0, 8'hA0);
        check("req_after_push", {28'd0, REQ}, 32'h1);
        expect_out(8'hA0, 2'd0);
        grant(4'b0001);
        check("req_after_pop", {28'd0, REQ}, 32'h0);
        tick();

        // Fill port 2, overflow push dropped, drain in order
        push1(2, 8'h11);
        push1(2, 8'h22);
        push1(2, 8'h33);
        push1(2, 8'h44);
        check("full_ready2", {31'd0, in_ready[2]}, 32'h0);
        push1(2, 8'h55);
        check("full_req", {28'd0, REQ}, 32'h4);
        expect_out(8'h11, 2'd2); grant(4'b0100);
        check("ready2_after_pop", {31'd0, in_ready[2]}, 32'h1);
        expect_out(8'h22, 2'd2); grant(4'b0100);
        expect_out(8'h33, 2'd2); grant(4'b0100);
        expect_out(8'h44, 2'd2); grant(4'b0100);
        check("port2_empty", {28'd0, REQ}, 32'h0);

        // Port 1: simultaneous push and pop with write-pointer wrap
        push1(1, 8'hA1);
        push1(1, 8'hA2);
        push1(1, 8'hA3);
        GNT = 4'b0010; expect_out(8'hA1, 2'd1);
        push1(1, 8'hB1);
        GNT = '0;
        check("pushpop_ready1", {31'd0, in_ready[1]}, 32'h1);
        GNT = 4'b0010; expect_out(8'hA2, 2'd1);
        push1(1, 8'hB2);
        GNT = '0;
        check("pushpop_req1", {28'd0, REQ}, 32'h2);
        push1(1, 8'hB3);
        check("count3_then_full", {31'd0, in_ready[1]}, 32'h0);
        expect_out(8'hA3, 2'd1); grant(4'b0010);
        expect_out(8'hB1, 2'd1); grant(4'b0010);
        expect_out(8'hB2, 2'd1); grant(4'b0010);
        expect_out(8'hB3, 2'd1); grant(4'b0010);
        check("port1_empty", {28'd0, REQ}, 32'h0);

        // Illegal grants: multi-hot, then grant on an empty port
        in_valid = 4'b0110;
        in_data  = 32'h00_C2_C1_00;
        tick();
        in_valid = '0;
        expect_err(); grant(4'b0110);
        check("req_after_multihot", {28'd0, REQ}, 32'h6);
        expect_err(); grant(4'b1000);
        check("req_after_empty_gnt", {28'd0, REQ}, 32'h6);
        tick();
        expect_out(8'hC1, 2'd1); grant(4'b0010);
        expect_out(8'hC2, 2'd2); grant(4'b0100);
        check("illegal_no_pop_empty", {28'd0, REQ}, 32'h0);

        // All four ports at once, then one grant per port back to back
        push_all(32'hD3_D2_D1_D0);
        check("all_req", {28'd0, REQ}, 32'hF);
        expect_out(8'hD0, 2'd0); grant(4'b0001);
        expect_out(8'hD1, 2'd1); grant(4'b0010);
        expect_out(8'hD2, 2'd2); grant(4'b0100);
        expect_out(8'hD3, 2'd3); grant(4'b1000);
        tick();
        check("hold_out_valid", {31'd0, out_valid}, 32'h0);
        check("hold_out_data", {24'd0, out_data}, 32'hD3);
        check("hold_out_port", {30'd0, out_port}, 32'h3);

        // Pushes on every port plus a pop in the same cycle
        push_all(32'hE3_E2_E1_E0);
        in_valid = 4'b1111;
        in_data  = 32'hF3_F2_F1_F0;
        GNT      = 4'b1000;
        expect_out(8'hE3, 2'd3);
        tick();
        in_valid = '0;
        GNT      = '0;
        push1(3, 8'hF4);
        check("two_each_req", {28'd0, REQ}, 32'hF);

        // Reset asserted right after a grant: pending output must vanish at once
        GNT = 4'b0001;
        tick();
        GNT   = '0;
        rst_n = 1'b0;
        #1;
        check("midrst_req", {28'd0, REQ}, 32'h0);
        check("midrst_in_ready", {28'd0, in_ready}, 32'hF);
        check("midrst_out_valid", {31'd0, out_valid}, 32'h0);
        check("midrst_out_data", {24'd0, out_data}, 32'h0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        expect_err(); grant(4'b0001);
        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arb_req_queue.md
ARB_REQ_QUEUE -- requirements
Module: arb_req_queue

Interface
REQ-001 Parameter DATA_W, default 8, payload width per port in bits.
REQ-002 Parameter DEPTH, default 4, entries per port queue; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  4  per-port write strobe; bit i belongs to port i.
REQ-006 in_data  input  4*DATA_W  per-port payload; port i occupies bits [i*DATA_W +: DATA_W].
REQ-007 in_ready  output  4  per-port space available.
REQ-008 REQ  output  4  per-port request to the round-robin arbiter.
REQ-009 GNT  input  4  grant from the arbiter; expected one-hot or zero.
REQ-010 out_valid  output  1  registered pulse marking a dequeued word.
REQ-011 out_data  output  DATA_W  dequeued payload, valid when out_valid=1.
REQ-012 out_port  output  2  source port index of out_data.
REQ-013 err_gnt  output  1  registered pulse flagging an illegal grant.

Function
REQ-014 Each port SHALL own an independent FIFO of DEPTH entries with read pointer, write pointer and occupancy count.
REQ-015 in_ready[i] SHALL equal (count[i] != DEPTH), decoded from registered count only; there is no same-cycle bypass from a pop.
REQ-016 A push on port i SHALL occur when in_valid[i]=1 and in_ready[i]=1 and SHALL store in_data for port i at the write pointer.
REQ-017 When in_valid[i]=1 and in_ready[i]=0, the word SHALL be dropped and state SHALL stay unchanged.
REQ-018 REQ[i] SHALL equal (count[i] != 0), combinational from registered count.
REQ-019 A legal grant is GNT one-hot with REQ set for the granted bit; it SHALL pop the head of that port in the same edge.
REQ-020 After a legal grant, out_valid=1, out_data=popped head and out_port=granted index SHALL be presented exactly one cycle later (latency 1).
REQ-021 With no legal grant, out_valid SHALL be 0 on the next cycle; out_data and out_port SHALL hold their last values.
REQ-022 An illegal grant is GNT with more than one bit set, or one bit set on an empty port. It SHALL cause no pop and no out_valid, and SHALL drive err_gnt=1 for one cycle.
REQ-023 GNT=0 SHALL be idle: no pop and no error.
REQ-024 A simultaneous push and pop on the same port SHALL leave count unchanged, advance both pointers, and keep FIFO order.
REQ-025 A push to an empty port SHALL raise REQ on the next cycle; it SHALL NOT be poppable in the same cycle.
REQ-026 A pop of the last entry SHALL drop REQ[i] on the next cycle.
REQ-027 Pointers SHALL be log2(DEPTH) bits and SHALL wrap modulo DEPTH.
REQ-028 count SHALL be log2(DEPTH)+1 bits, SHALL never exceed DEPTH and SHALL never underflow.
REQ-029 Ports SHALL be fully independent: pushes on all four ports plus one pop may occur in one cycle.

Reset
REQ-030 While rst_n=0, all pointers and counts SHALL be 0, so in_ready=4'b1111 and REQ=4'b0000.
REQ-031 While rst_n=0, out_valid=0, out_data=0, out_port=0 and err_gnt=0.
REQ-032 Reset asserted mid-operation SHALL discard all queued words immediately; there SHALL be no output after release until new pushes occur.
REQ-033 FIFO storage arrays need not be reset.

Structure
REQ-034 A shared package SHALL hold NUM_PORTS=4, PORT_W=2 and the default DATA_W/DEPTH constants.
REQ-035 Per-port storage SHALL be one sub-module, arb_port_fifo, instantiated four times.
REQ-036 The top level SHALL hold only grant decode, legality check, output mux and output registers.

Verification
REQ-037 Reset, then push 8'hA0 on port 0; GNT=4'b0001 the next cycle -> one cycle later out_valid=1, out_data=8'hA0, out_port=0, REQ=4'b0000.
REQ-038 Push 8'h11, 8'h22, 8'h33, 8'h44 on port 2 -> in_ready[2]=0. A fifth push 8'h55 is dropped. Grant port 2 four times -> outputs 11, 22, 33, 44 in order.
REQ-039 Port 1 holds 3 entries; push and grant port 1 in the same cycle -> count stays 3, in_ready[1]=1, pop order preserved across pointer wrap.
REQ-040 GNT=4'b0110 with ports 1 and 2 non-empty -> err_gnt pulses one cycle, no out_valid, counts unchanged. GNT=4'b1000 with port 3 empty -> same.
REQ-041 Fill all ports, drive the arbiter sequence 0001, 0010, 0100, 1000 -> out_port 0, 1, 2, 3 on consecutive cycles.
REQ-042 Assert rst_n=0 with all ports holding 2 entries -> REQ=0, in_ready=4'b1111, out_valid=0 immediately. After release, GNT=4'b0001 -> err_gnt=1.
